mv_fifo_buffer: RTL and testbench

//  Parametrised successor of the single motion-vector holding register.

---
 rtl/mv_fifo_buffer.sv | 136 +++++++++++++
 tb/tb_mv_fifo_buffer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mv_fifo_buffer.sv
// Motion-vector FIFO between the MV producer and the cost/prediction stage.
// Show-ahead head, optional per-component saturation with a clamp tag.
module mv_fifo_buffer #(
    parameter int MV_W     = 8,
    parameter int DEPTH    = 4,
    parameter bit CLAMP_EN = 1'b1,
    parameter int MV_RANGE = 64
) (
    input  logic                       CLK,
    input  logic                       RST_ASYNC_N,
    input  logic                       CLEAR,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic [2*MV_W-1:0]          DATA_IN,
    output logic                       OUT_VALID,
    input  logic                       OUT_READY,
    output logic [2*MV_W-1:0]          DATA_OUT,
    output logic                       OUT_CLAMPED,
    output logic [$clog2(DEPTH):0]     COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic signed [MV_W-1:0] POS = MV_W'(MV_RANGE);
    localparam logic signed [MV_W-1:0] NEG = MV_W'(-MV_RANGE);
    localparam logic [CW-1:0]          FULL = CW'(DEPTH);

    logic [2*MV_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  flag_q;

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic push, pop;
    logic do_push, do_pop;

    logic signed [MV_W-1:0] h_in, v_in;
    logic signed [MV_W-1:0] h_st, v_st;
    logic                   clamp_hit;

    assign h_in = DATA_IN[2*MV_W-1:MV_W];
    assign v_in = DATA_IN[MV_W-1:0];

    generate
        if (CLAMP_EN) begin : g_clamp
            always_comb begin
                h_st = h_in;
                v_st = v_in;
                if (h_in > POS) begin
                    h_st = POS;
                end else if (h_in < NEG) begin
                    h_st = NEG;
                end
                if (v_in > POS) begin
                    v_st = POS;
                end else if (v_in < NEG) begin
                    v_st = NEG;
                end
            end
            assign clamp_hit = (h_st != h_in) || (v_st != v_in);
        end else begin : g_pass
            assign h_st      = h_in;
            assign v_st      = v_in;
            assign clamp_hit = 1'b0;
        end
    endgenerate

    // Handshake flags depend on occupancy only, never on the other side.
    assign IN_READY  = (cnt_q != FULL);
    assign OUT_VALID = (cnt_q != '0);

    assign push    = IN_VALID & IN_READY;
    assign pop     = OUT_VALID & OUT_READY;
    assign do_push = push & ~CLEAR;
    assign do_pop  = pop & ~CLEAR;

    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        unique case (1'b1)
            CLEAR: begin
                wp_d  = '0;
                rp_d  = '0;
                cnt_d = '0;
            end
            do_push & do_pop: begin
                wp_d = wp_q + 1'b1;
                rp_d = rp_q + 1'b1;
            end
            do_push & ~do_pop: begin
                wp_d  = wp_q + 1'b1;
                cnt_d = cnt_q + 1'b1;
            end
            ~do_push & do_pop: begin
                rp_d  = rp_q + 1'b1;
                cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
        if (!RST_ASYNC_N) begin
            flag_q <= '0;
        end else if (do_push) begin
            flag_q[wp_q] <= clamp_hit;
        end
    end

    // Payload is never read while empty, so it needs no reset.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wp_q] <= {h_st, v_st};
        end
    end

    assign DATA_OUT    = OUT_VALID ? mem[rp_q] : '0;
    assign OUT_CLAMPED = OUT_VALID ? flag_q[rp_q] : 1'b0;
    assign COUNT       = cnt_q;

endmodule

// File: tb/tb_mv_fifo_buffer.sv
// Directed bench for mv_fifo_buffer: clamped instance plus a pass-through one.
module tb_mv_fifo_buffer;

    logic        CLK = 1'b0;
    logic        RST_ASYNC_N;
    logic        CLEAR, IN_VALID, OUT_READY;
    logic [15:0] DATA_IN;
    logic        IN_READY, OUT_VALID, OUT_CLAMPED;
    logic [15:0] DATA_OUT;
    logic [2:0]  COUNT;

    logic        b_in_valid, b_out_ready;
    logic [15:0] b_data_in;
    logic        b_in_ready, b_out_valid, b_out_clamped;
    logic [15:0] b_data_out;
    logic [2:0]  b_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] fill_v [4];

    always #5 CLK = ~CLK;

    mv_fifo_buffer #(.MV_W(8), .DEPTH(4), .CLAMP_EN(1'b1), .MV_RANGE(64)) u_dut (
        .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .CLEAR(CLEAR),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .DATA_IN(DATA_IN),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .DATA_OUT(DATA_OUT),
        .OUT_CLAMPED(OUT_CLAMPED), .COUNT(COUNT)
    );

    mv_fifo_buffer #(.MV_W(8), .DEPTH(4), .CLAMP_EN(1'b0), .MV_RANGE(64)) u_raw (
        .CLK(CLK), .RST_ASYNC_N(RST_ASYNC_N), .CLEAR(1'b0),
        .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .DATA_IN(b_data_in),
        .OUT_VALID(b_out_valid), .OUT_READY(b_out_ready), .DATA_OUT(b_data_out),
        .OUT_CLAMPED(b_out_clamped), .COUNT(b_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_ASYNC_N = 1'b0;
        CLEAR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; DATA_IN = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_data_in = '0;
        fill_v[0] = 16'h0102; fill_v[1] = 16'h0304;
        fill_v[2] = 16'h0506; fill_v[3] = 16'h0708;
        #3;
        chk("rst_count", COUNT, 0);
        chk("rst_out_valid", OUT_VALID, 0);
        chk("rst_in_ready", IN_READY, 1);
        chk("rst_data_out", DATA_OUT, 0);
        #9 RST_ASYNC_N = 1'b1;
        step();

        // fill to full
        IN_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            DATA_IN = fill_v[i];
            step();
        end
        chk("full_count", COUNT, 4);
        chk("full_in_ready", IN_READY, 0);
        chk("full_head", DATA_OUT, 16'h0102);
        DATA_IN = 16'h0909;
        step();
        chk("ovf_count", COUNT, 4);
        IN_VALID = 1'b0;
        OUT_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", DATA_OUT, fill_v[i]);
            chk("drain_clamped", OUT_CLAMPED, 0);
            step();
        end
        OUT_READY = 1'b0;
        chk("empty_count", COUNT, 0);
        chk("empty_out_valid", OUT_VALID, 0);
        chk("empty_data_out", DATA_OUT, 0);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        chk("pop_empty_count", COUNT, 0);

        // clamp {100,-100} -> {64,-64}
        IN_VALID = 1'b1; DATA_IN = 16'h649C;
        step();
        IN_VALID = 1'b0;
        chk("clamp_data", DATA_OUT, 16'h40C0);
        chk("clamp_flag", OUT_CLAMPED, 1);
        OUT_READY = 1'b1; step(); OUT_READY = 1'b0;
        IN_VALID = 1'b1; DATA_IN = 16'h40C0;
        step();
        IN_VALID = 1'b0;
        chk("edge_data", DATA_OUT, 16'h40C0);
        chk("edge_flag", OUT_CLAMPED, 0);
        OUT_READY = 1'b1; step(); OUT_READY = 1'b0;
        IN_VALID = 1'b1; DATA_IN = 16'h7F81;
        step();
        IN_VALID = 1'b0;
        chk("sat_max_data", DATA_OUT, 16'h40C0);
        chk("sat_max_flag", OUT_CLAMPED, 1);
        OUT_READY = 1'b1; step(); OUT_READY = 1'b0;
        chk("clamp_done_count", COUNT, 0);

        // streaming at COUNT=1
        IN_VALID = 1'b1; DATA_IN = 16'h0000;
        step();
        OUT_READY = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            DATA_IN = 16'(i);
            chk("stream_count", COUNT, 1);
            chk("stream_data", DATA_OUT, 32'(i - 1));
            step();
        end
        IN_VALID = 1'b0; OUT_READY = 1'b0;
        chk("stream_end_count", COUNT, 1);
        chk("stream_end_data", DATA_OUT, 16'd20);
        OUT_READY = 1'b1; step(); OUT_READY = 1'b0;
        chk("stream_drain_count", COUNT, 0);

        // CLEAR beats push+pop at COUNT=2
        IN_VALID = 1'b1;
        DATA_IN = 16'h1111; step();
        DATA_IN = 16'h2222; step();
        chk("pre_clear_count", COUNT, 2);
        DATA_IN = 16'h3333; OUT_READY = 1'b1; CLEAR = 1'b1;
        step();
        CLEAR = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        chk("clear_count", COUNT, 0);
        chk("clear_out_valid", OUT_VALID, 0);
        IN_VALID = 1'b1; DATA_IN = 16'h0101;
        step();
        IN_VALID = 1'b0;
        chk("post_clear_count", COUNT, 1);
        chk("post_clear_data", DATA_OUT, 16'h0101);
        OUT_READY = 1'b1; step(); OUT_READY = 1'b0;
        chk("post_clear_empty", OUT_VALID, 0);

        // pass-through instance
        b_in_valid = 1'b1; b_data_in = 16'h7F81;
        step();
        b_in_valid = 1'b0;
        chk("raw_data", b_data_out, 16'h7F81);
        chk("raw_flag", b_out_clamped, 0);
        chk("raw_count", b_count, 1);

        // asynchronous reset mid-run with entries held
        IN_VALID = 1'b1; DATA_IN = 16'h0A0B;
        step(); step();
        IN_VALID = 1'b0;
        chk("pre_rst_count", COUNT, 2);
        RST_ASYNC_N = 1'b0;
        #2;
        chk("arst_count", COUNT, 0);
        chk("arst_out_valid", OUT_VALID, 0);
        chk("arst_data_out", DATA_OUT, 0);
        chk("arst_in_ready", IN_READY, 1);
        chk("arst_raw_count", b_count, 0);
        step();
        RST_ASYNC_N = 1'b1;
        step();
        chk("after_rst_count", COUNT, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
